mem_ctrl_arbiter: RTL and testbench
===================================

// Module: mem_ctrl_arbiter
// PURPOSE
//  Memory-side responder for the cache request protocol.
//  - Accepts icache reads (iREN/iaddr) and dcache reads/writes (dREN/dWEN/daddr/dstore).
//  - Arbitrates one single-word RAM access at a time; drives ramREN/ramWEN/ramaddr/ramstore.
//  - Returns iwait/iload and dwait/dload.
//  - Sits between the cache pair and the RAM model; the caches hold REN/WEN high until wait falls.
// PARAMETERS
//  TIMEOUT       64   max cycles in a service state before forced abort with err set
//  STARVE_LIMIT  4    consecutive dcache grants with iREN pending before icache is forced next
// PORTS
//  CLK       in   1    clock
//  nRST      in   1    reset, asynchronous, active-low
//  iREN      in   1    icache read request
//  iaddr     in   32   icache word address
//  iwait     out  1    0 = iload valid this cycle (completion), else 1
//  iload     out  32   instruction word
//  dREN      in   1    dcache read request
//  dWEN      in   1    dcache write request (dWEN wins if both set)
//  daddr     in   32   dcache word address
//  dstore    in   32   dcache write data
//  dwait     out  1    0 = dcache access completes this cycle, else 1
//  dload     out  32   data read word
//  ramREN    out  1    RAM read enable
//  ramWEN    out  1    RAM write enable
//  ramaddr   out  32   RAM address (latched at grant)
//  ramstore  out  32   RAM write data (latched at grant)
//  ramload   in   32   RAM read data
//  ramstate  in   2    ramstate_t: FREE/BUSY/ACCESS/ERROR
//  err       out  1    sticky: RAM ERROR or timeout seen; cleared only by reset
// BEHAVIOUR
//  - Reset: state IDLE, iwait=dwait=1, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0, err=0.
//    Reset also clears tmo_cnt and starve_cnt, and aborts any access (RAM enables drop immediately).
//  - States: IDLE, IREAD, DREAD, DWRITE.
//  - IDLE grant, registered; no RAM enables are driven in IDLE:
//      dWEN -> DWRITE;  else dREN -> DREAD;  else iREN -> IREAD.
//      Exception: starve_cnt==STARVE_LIMIT and iREN -> IREAD.
//      On grant, latch address (and dstore for DWRITE) into ramaddr/ramstore.
//  - Service states drive the matching RAM enable from the latched regs, held constant until exit.
//    tmo_cnt increments each service cycle.
//  - Completion: in a service state with ramstate==ACCESS, that port's wait=0 for exactly one cycle
//    (combinational). Read data comes from ramload in the same cycle. Next state IDLE.
//  - Min latency: request seen in IDLE at cycle N -> earliest wait=0 at N+1. RAM latency adds on top.
//  - One IDLE bubble between back-to-back accesses. A REN still high after completion is a new request.
//  - starve_cnt:
//      +1 on each D grant while iREN=1, saturating at STARVE_LIMIT.
//      Cleared on an I grant, and when iREN=0 at a D grant.
//  - Abort: requester drops REN/WEN before ACCESS -> IDLE next cycle, enables drop, wait stays 1,
//    no data returned.
//  - ramstate==ERROR, or tmo_cnt==TIMEOUT-1 without ACCESS -> IDLE, err<=1, wait stays 1.
//    The requester retries.
//  - Requests are sampled only in IDLE. Changes to the other port's inputs during service are ignored.
//  - Address/data changes from the served port mid-service are ignored (latched values used).
//  - iload/dload are 0 when the port's wait=1.
//  - Never assert ramREN and ramWEN together. Never assert both waits low in one cycle.
// STRUCTURE
//  - Add to cpu_types_pkg:
//      typedef enum logic [1:0] {MC_IDLE, MC_IREAD, MC_DREAD, MC_DWRITE} memctl_state_t.
//  - Reuse word_t and ramstate_t from cpu_types_pkg.
//  - Ports map 1:1 onto caches_if plus the ram-side signals of cpu_ram_if.
//  - Single module. tmo_cnt (clog2(TIMEOUT) bits) and starve_cnt are inline counters, no sub-module.
//  - One always_ff for state, latches and counters; one always_comb for next-state and outputs.
// TESTING
//  - Reset mid-DWRITE (ramWEN=1): nRST low -> same-cycle ramWEN=0, dwait=1, err=0;
//    state IDLE after release.
//  - iREN=1, iaddr=0x40, RAM ACCESS 2 cycles after grant:
//    ramREN=1, ramaddr=0x40 for 2 cycles; then iwait=0 for 1 cycle, iload=ramload=0x8C220004.
//  - iREN & dWEN together, daddr=0x80, dstore=0xDEADBEEF:
//    DWRITE first (ramWEN=1, ramstore=0xDEADBEEF, dwait=0 at ACCESS); IREAD granted after one IDLE bubble.
//  - Starvation: STARVE_LIMIT=4, dREN and iREN held high:
//    4 DREAD completions, then 5th grant is IREAD; starve_cnt=0 afterward.
//  - Abort: dREN dropped one cycle into DREAD (ramstate BUSY) ->
//    next cycle IDLE, ramREN=0, dwait never 0, err=0.
//  - ramstate=ERROR during IREAD -> IDLE, iwait=1, err=1.
//    Separately, RAM held BUSY 64 cycles -> abort, err=1.

Source files
------------

// File: rtl/mem_ctrl_arbiter_pkg.sv
// Shared CPU types: RAM word, RAM handshake state
// and the memory-controller arbiter state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_IREAD,
        MC_DREAD,
        MC_DWRITE
    } memctl_state_t;

endpackage

// File: rtl/mem_ctrl_arbiter_if.sv
// Cache-pair request bus plus the RAM-side signals
// seen by the memory controller arbiter.
interface mem_ctrl_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      err;

    modport slave (
        input  iREN, iaddr,
        input  dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, iload,
        output dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore,
        output err
    );

    modport master (
        output iREN, iaddr,
        output dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, iload,
        input  dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  err
    );

endinterface

// File: rtl/mem_ctrl_arbiter.sv
// Single-port RAM arbiter for the icache/dcache pair:
// one word access at a time, starvation guard, timeout.
module mem_ctrl_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT      = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    mem_ctrl_arbiter_if.slave   mc
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    memctl_state_t state, state_n;
    word_t         addr_q, store_q;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] starve_cnt;
    logic          err_q;
    logic          req, done, fault;

    always_comb begin
        state_n     = state;
        req         = 1'b0;
        done        = 1'b0;
        fault       = 1'b0;
        mc.ramREN   = 1'b0;
        mc.ramWEN   = 1'b0;
        mc.ramaddr  = addr_q;
        mc.ramstore = store_q;
        mc.err      = err_q;

        unique case (state)
            MC_IDLE: begin
                if (starve_cnt == STARVE_MAX && mc.iREN)
                    state_n = MC_IREAD;
                else if (mc.dWEN)
                    state_n = MC_DWRITE;
                else if (mc.dREN)
                    state_n = MC_DREAD;
                else if (mc.iREN)
                    state_n = MC_IREAD;
            end
            MC_IREAD: begin
                mc.ramREN = 1'b1;
                req       = mc.iREN;
            end
            MC_DREAD: begin
                mc.ramREN = 1'b1;
                req       = mc.dREN;
            end
            MC_DWRITE: begin
                mc.ramWEN = 1'b1;
                req       = mc.dWEN;
            end
        endcase

        // A dropped request wins over a same-cycle ACCESS.
        if (state != MC_IDLE) begin
            if (!req) begin
                state_n = MC_IDLE;
            end else if (mc.ramstate == ACCESS) begin
                done    = 1'b1;
                state_n = MC_IDLE;
            end else if (mc.ramstate == ERROR || tmo_cnt == TMO_LAST) begin
                fault   = 1'b1;
                state_n = MC_IDLE;
            end
        end

        mc.iwait = !(done && state == MC_IREAD);
        mc.dwait = !(done && state != MC_IREAD);
        mc.iload = (done && state == MC_IREAD) ? mc.ramload : '0;
        mc.dload = (done && state == MC_DREAD) ? mc.ramload : '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= MC_IDLE;
            addr_q     <= '0;
            store_q    <= '0;
            tmo_cnt    <= '0;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_n;

            if (state == MC_IDLE)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            if (fault)
                err_q <= 1'b1;

            if (state == MC_IDLE && state_n != MC_IDLE) begin
                if (state_n == MC_IREAD) begin
                    addr_q     <= mc.iaddr;
                    starve_cnt <= '0;
                end else begin
                    addr_q <= mc.daddr;
                    if (state_n == MC_DWRITE)
                        store_q <= mc.dstore;
                    if (!mc.iREN)
                        starve_cnt <= '0;
                    else if (starve_cnt != STARVE_MAX)
                        starve_cnt <= starve_cnt + SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Directed + randomized bench for mem_ctrl_arbiter with a
// transaction-level grant/memory reference model.
module tb_mem_ctrl_arbiter;
    import cpu_types_pkg::*;

    localparam int SL = 4;
    localparam int TO = 64;
    localparam int KN = 0;
    localparam int KI = 1;
    localparam int KR = 2;
    localparam int KW = 3;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    mem_ctrl_arbiter_if bus ();

    mem_ctrl_arbiter #(
        .TIMEOUT      (TO),
        .STARVE_LIMIT (SL)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .mc   (bus)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    int    sc    = 0;
    logic  exp_err = 1'b0;
    word_t ram  [word_t];
    word_t refm [word_t];

    function automatic word_t dflt(word_t a);
        return (a * 32'h9E3779B1) ^ 32'h0000_1234;
    endfunction

    function automatic word_t ramrd(word_t a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    function automatic word_t refrd(word_t a);
        return refm.exists(a) ? refm[a] : dflt(a);
    endfunction

    // Grant choice from the priority and starvation rules.
    function automatic int pick(logic i, logic r, logic w, int s);
        if (s == SL && i) return KI;
        if (w) return KW;
        if (r) return KR;
        if (i) return KI;
        return KN;
    endfunction

    task automatic chk(string tag, word_t obs, word_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t rnd_addr();
        return word_t'($urandom_range(0, 15)) << 2;
    endfunction

    // One full transaction, starting from an IDLE cycle.
    task automatic access(logic i, logic r, logic w,
                          word_t ia, word_t da, word_t ds, int lat);
        int    k;
        word_t ea;
        logic  last;
        k = pick(i, r, w, sc);
        bus.iREN     = i;
        bus.dREN     = r;
        bus.dWEN     = w;
        bus.iaddr    = ia;
        bus.daddr    = da;
        bus.dstore   = ds;
        bus.ramstate = FREE;
        bus.ramload  = $urandom;
        @(negedge CLK);
        chk("idle_ramREN", bus.ramREN, 0);
        chk("idle_ramWEN", bus.ramWEN, 0);
        chk("idle_iwait", bus.iwait, 1);
        chk("idle_dwait", bus.dwait, 1);
        chk("idle_err", bus.err, exp_err);
        if (k == KN) begin
            @(posedge CLK); #1;
            return;
        end
        if (k == KI) sc = 0;
        else sc = i ? ((sc < SL) ? sc + 1 : SL) : 0;
        ea = (k == KI) ? ia : da;
        for (int c = 0; c <= lat; c++) begin
            @(posedge CLK); #1;
            last = (c == lat);
            bus.iaddr  = $urandom;
            bus.daddr  = $urandom;
            bus.dstore = $urandom;
            if (k == KI) begin
                bus.dREN = 1'($urandom);
                bus.dWEN = 1'($urandom);
            end else begin
                bus.iREN = 1'($urandom);
            end
            bus.ramstate = last ? ACCESS : BUSY;
            bus.ramload  = (last && k != KW) ? ramrd(bus.ramaddr) : $urandom;
            if (last && k == KW && bus.ramWEN)
                ram[bus.ramaddr] = bus.ramstore;
            @(negedge CLK);
            chk("svc_ramREN", bus.ramREN, (k != KW));
            chk("svc_ramWEN", bus.ramWEN, (k == KW));
            chk("svc_ramaddr", bus.ramaddr, ea);
            if (k == KW) chk("svc_ramstore", bus.ramstore, ds);
            chk("svc_iwait", bus.iwait, !(last && k == KI));
            chk("svc_dwait", bus.dwait, !(last && k != KI));
            chk("svc_iload", bus.iload, (last && k == KI) ? refrd(ea) : 0);
            if (!(last && k == KW))
                chk("svc_dload", bus.dload, (last && k == KR) ? refrd(ea) : 0);
            chk("svc_err", bus.err, exp_err);
        end
        if (k == KW) refm[ea] = ds;
        @(posedge CLK); #1;
        bus.iREN     = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.ramstate = FREE;
    endtask

    initial begin
        nRST         = 1'b0;
        bus.iREN     = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.iaddr    = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = 32'hA5A5_5A5A;
        bus.ramstate = FREE;
        ram[32'h40]  = 32'h8C22_0004;
        refm[32'h40] = 32'h8C22_0004;

        @(negedge CLK);
        chk("rst_iwait", bus.iwait, 1);
        chk("rst_dwait", bus.dwait, 1);
        chk("rst_iload", bus.iload, 0);
        chk("rst_dload", bus.dload, 0);
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramWEN", bus.ramWEN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ramstore", bus.ramstore, 0);
        chk("rst_err", bus.err, 0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // icache read, RAM ACCESS two cycles after grant
        access(1, 0, 0, 32'h40, 0, 0, 2);
        // write wins over icache, then icache after a bubble
        access(1, 0, 1, 32'h44, 32'h80, 32'hDEAD_BEEF, 1);
        access(1, 0, 0, 32'h80, 0, 0, 0);
        // starvation: four data reads, then the icache
        for (int n = 0; n < SL + 2; n++)
            access(1, 1, 0, rnd_addr(), rnd_addr(), 0, 0);

        for (int n = 0; n < 40; n++)
            access(1'($urandom), 1'($urandom), 1'($urandom),
                   rnd_addr(), rnd_addr(), $urandom,
                   int'($urandom_range(0, 3)));

        // abort: dREN dropped one cycle into DREAD
        bus.dREN  = 1'b1;
        bus.daddr = 32'h20;
        bus.iREN  = 1'b0;
        sc = 0;
        @(posedge CLK); #1;
        bus.ramstate = BUSY;
        @(negedge CLK);
        chk("abt_ramREN", bus.ramREN, 1);
        chk("abt_dwait0", bus.dwait, 1);
        @(posedge CLK); #1;
        bus.dREN = 1'b0;
        @(negedge CLK);
        chk("abt_dwait1", bus.dwait, 1);
        @(posedge CLK); #1;
        bus.ramstate = FREE;
        @(negedge CLK);
        chk("abt_ramREN_off", bus.ramREN, 0);
        chk("abt_dwait2", bus.dwait, 1);
        chk("abt_err", bus.err, 0);
        @(posedge CLK); #1;
        access(0, 1, 0, 0, 32'h20, 0, 1);

        // RAM ERROR during IREAD
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h10;
        @(posedge CLK); #1;
        bus.ramstate = ERROR;
        sc = 0;
        @(negedge CLK);
        chk("rerr_iwait", bus.iwait, 1);
        chk("rerr_iload", bus.iload, 0);
        @(posedge CLK); #1;
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        exp_err      = 1'b1;
        @(negedge CLK);
        chk("rerr_ramREN", bus.ramREN, 0);
        chk("rerr_iwait2", bus.iwait, 1);
        chk("rerr_err", bus.err, 1);
        @(posedge CLK); #1;
        access(1, 0, 0, 32'h10, 0, 0, 0);

        // clean reset, then timeout on a stuck RAM
        nRST = 1'b0;
        @(negedge CLK);
        chk("rst2_err", bus.err, 0);
        nRST = 1'b1;
        exp_err = 1'b0;
        sc = 0;
        @(posedge CLK); #1;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h30;
        @(posedge CLK); #1;
        bus.ramstate = BUSY;
        for (int c = 0; c < TO; c++) begin
            @(negedge CLK);
            chk("tmo_ramREN", bus.ramREN, 1);
            chk("tmo_dwait", bus.dwait, 1);
            @(posedge CLK); #1;
        end
        bus.dREN = 1'b0;
        exp_err  = 1'b1;
        @(negedge CLK);
        chk("tmo_ramREN_off", bus.ramREN, 0);
        chk("tmo_err", bus.err, 1);
        @(posedge CLK); #1;
        bus.ramstate = FREE;

        // reset in the middle of a write
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h3C;
        bus.dstore = 32'h1234_5678;
        @(posedge CLK); #1;
        bus.ramstate = BUSY;
        @(negedge CLK);
        chk("mrst_ramWEN_on", bus.ramWEN, 1);
        @(posedge CLK); #1;
        nRST = 1'b0;
        #1;
        chk("mrst_ramWEN", bus.ramWEN, 0);
        chk("mrst_dwait", bus.dwait, 1);
        chk("mrst_err", bus.err, 0);
        bus.dWEN     = 1'b0;
        bus.ramstate = FREE;
        @(negedge CLK);
        nRST    = 1'b1;
        exp_err = 1'b0;
        sc      = 0;
        @(posedge CLK); #1;
        access(0, 1, 0, 0, 32'h80, 0, 2);
        access(1, 0, 0, 32'h40, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
